// File: rtl/stack_sequencer_pkg.sv
// rtl/stack_sequencer_pkg.sv - shared widths, FSM state codes and request kinds for the stack sequencer
package stack_sequencer_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;
    localparam int FLAG_W_DEF = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PUSH_H = 3'd1;
    localparam logic [2:0] ST_PUSH_L = 3'd2;
    localparam logic [2:0] ST_PUSH_F = 3'd3;
    localparam logic [2:0] ST_POP_F  = 3'd4;
    localparam logic [2:0] ST_POP_L  = 3'd5;
    localparam logic [2:0] ST_POP_H  = 3'd6;
    localparam logic [2:0] ST_LOAD   = 3'd7;

    typedef enum logic [1:0] {
        KIND_CALL = 2'd0,
        KIND_INT  = 2'd1,
        KIND_RET  = 2'd2,
        KIND_RTI  = 2'd3
    } req_kind_e;

endpackage

// File: rtl/stack_sequencer_if.sv
// rtl/stack_sequencer_if.sv - data-memory stack port between the sequencer (master) and memory (slave)
interface stack_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              mem_re;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/stack_sequencer_stack_pointer.sv
// rtl/stack_sequencer_stack_pointer.sv - stack pointer register with inc/dec and optional bound guard
// Optional feature macro: STACK_GUARD_EN (flags pushes at sp==0 and pops at sp==SP_INIT).
module stack_sequencer_stack_pointer #(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_plus1,
    output logic              push_block,
    output logic              pop_block
);
    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;

    always_comb begin
        sp_d = sp_q;
        if (inc) begin
            sp_d = sp_q + 1'b1;
        end else if (dec) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= SP_INIT;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp       = sp_q;
    assign sp_plus1 = sp_q + 1'b1;

`ifdef STACK_GUARD_EN
    assign push_block = (sp_q == '0);
    assign pop_block  = (sp_q == SP_INIT);
`else
    assign push_block = 1'b0;
    assign pop_block  = 1'b0;
`endif

endmodule

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - sequences CALL/INT pushes and RET/RTI pops on the data-memory stack port
// Optional feature macro: STACK_GUARD_EN (adds sticky stack_fault and suppresses out-of-range transfers).
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                FLAG_W  = FLAG_W_DEF,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                call_req,
    input  logic                int_req,
    input  logic                ret_req,
    input  logic                rti_req,
    input  logic [2*DATA_W-1:0] pc_in,
    input  logic [FLAG_W-1:0]   flags_in,
    stack_sequencer_if.master   mem,
    output logic                busy,
    output logic [2*DATA_W-1:0] pc_out,
    output logic                pc_load,
    output logic [FLAG_W-1:0]   flags_out,
    output logic                flags_load,
    output logic                int_ack,
`ifdef STACK_GUARD_EN
    output logic                stack_fault,
`endif
    output logic [ADDR_W-1:0]   sp
);
    logic [2:0]          state_q, state_d;
    req_kind_e           kind_q, kind_d;
    logic                int_pend_q, int_pend_d;
    logic [2*DATA_W-1:0] hold_pc_q, hold_pc_d;
    logic [FLAG_W-1:0]   hold_flags_q, hold_flags_d;
    logic [DATA_W-1:0]   pc_lo_q, pc_lo_d;
    logic [2*DATA_W-1:0] pc_out_q, pc_out_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                fault_q, fault_d;

    logic [ADDR_W-1:0] sp_plus1;
    logic              push_block, pop_block;
    logic              sp_inc, sp_dec, abort;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we, re;

    stack_sequencer_stack_pointer #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
        .clk        (clk),
        .rst        (rst),
        .inc        (sp_inc),
        .dec        (sp_dec),
        .sp         (sp),
        .sp_plus1   (sp_plus1),
        .push_block (push_block),
        .pop_block  (pop_block)
    );

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        hold_pc_d    = hold_pc_q;
        hold_flags_d = hold_flags_q;
        pc_lo_d      = pc_lo_q;
        pc_out_d     = pc_out_q;
        flags_d      = flags_q;
        int_pend_d   = int_pend_q | (int_req & (state_q != ST_IDLE));
        addr         = sp;
        wdata        = '0;
        we           = 1'b0;
        re           = 1'b0;
        sp_inc       = 1'b0;
        sp_dec       = 1'b0;
        pc_load      = 1'b0;
        flags_load   = 1'b0;
        int_ack      = 1'b0;
        abort        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (int_req || int_pend_q) begin
                    kind_d       = KIND_INT;
                    hold_pc_d    = pc_in;
                    hold_flags_d = flags_in;
                    state_d      = ST_PUSH_H;
                end else if (rti_req) begin
                    kind_d  = KIND_RTI;
                    state_d = ST_POP_F;
                end else if (ret_req) begin
                    kind_d  = KIND_RET;
                    state_d = ST_POP_L;
                end else if (call_req) begin
                    kind_d    = KIND_CALL;
                    hold_pc_d = pc_in;
                    state_d   = ST_PUSH_H;
                end
            end
            ST_PUSH_H, ST_PUSH_L, ST_PUSH_F: begin
                if (push_block) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    we     = 1'b1;
                    sp_dec = 1'b1;
                    if (state_q == ST_PUSH_H) begin
                        wdata   = hold_pc_q[2*DATA_W-1:DATA_W];
                        state_d = ST_PUSH_L;
                    end else if (state_q == ST_PUSH_L) begin
                        wdata   = hold_pc_q[DATA_W-1:0];
                        state_d = (kind_q == KIND_INT) ? ST_PUSH_F : ST_IDLE;
                    end else begin
                        wdata   = {{(DATA_W-FLAG_W){1'b0}}, hold_flags_q};
                        int_ack = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_POP_F, ST_POP_L, ST_POP_H: begin
                if (pop_block) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    re     = 1'b1;
                    addr   = sp_plus1;
                    sp_inc = 1'b1;
                    // Each pop state consumes the word read by the previous one.
                    if (state_q == ST_POP_F) begin
                        state_d = ST_POP_L;
                    end else if (state_q == ST_POP_L) begin
                        if (kind_q == KIND_RTI) flags_d = mem.mem_rdata[FLAG_W-1:0];
                        state_d = ST_POP_H;
                    end else begin
                        pc_lo_d = mem.mem_rdata;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                pc_load    = 1'b1;
                flags_load = (kind_q == KIND_RTI);
                pc_out_d   = {mem.mem_rdata, pc_lo_q};
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // An aborted INT would otherwise retry forever against a full stack.
        if (int_ack || (abort && kind_q == KIND_INT)) int_pend_d = 1'b0;
        fault_d = fault_q | abort;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            kind_q       <= KIND_CALL;
            int_pend_q   <= 1'b0;
            hold_pc_q    <= '0;
            hold_flags_q <= '0;
            pc_lo_q      <= '0;
            pc_out_q     <= '0;
            flags_q      <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            int_pend_q   <= int_pend_d;
            hold_pc_q    <= hold_pc_d;
            hold_flags_q <= hold_flags_d;
            pc_lo_q      <= pc_lo_d;
            pc_out_q     <= pc_out_d;
            flags_q      <= flags_d;
            fault_q      <= fault_d;
        end
    end

    // The high half arrives during LOAD, so bypass it onto pc_out alongside the pc_load pulse.
    assign pc_out        = (state_q == ST_LOAD) ? {mem.mem_rdata, pc_lo_q} : pc_out_q;
    assign flags_out     = flags_q;
    assign busy          = (state_q != ST_IDLE);
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;
    assign mem.mem_we    = we;
    assign mem.mem_re    = re;

`ifdef STACK_GUARD_EN
    assign stack_fault = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - directed self-checking bench for stack_sequencer with a registered memory model
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        call_req = 1'b0, int_req = 1'b0, ret_req = 1'b0, rti_req = 1'b0;
    logic [31:0] pc_in = '0;
    logic [3:0]  flags_in = '0;
    logic        busy, pc_load, flags_load, int_ack;
    logic [31:0] pc_out;
    logic [3:0]  flags_out;
    logic [11:0] sp;
`ifdef STACK_GUARD_EN
    logic        stack_fault;
`endif

    stack_sequencer_if #(.DATA_W(16), .ADDR_W(12)) bus ();

    stack_sequencer dut (
        .clk        (clk),
        .rst        (rst_n),
        .call_req   (call_req),
        .int_req    (int_req),
        .ret_req    (ret_req),
        .rti_req    (rti_req),
        .pc_in      (pc_in),
        .flags_in   (flags_in),
        .mem        (bus),
        .busy       (busy),
        .pc_out     (pc_out),
        .pc_load    (pc_load),
        .flags_out  (flags_out),
        .flags_load (flags_load),
        .int_ack    (int_ack),
`ifdef STACK_GUARD_EN
        .stack_fault(stack_fault),
`endif
        .sp         (sp)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];
    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    logic [27:0] wq[$];
    logic [11:0] rq[$];
    int busy_cycles, acks, ack_pos, loads;
    logic [31:0] pc_seen;
    logic [3:0]  flags_seen;
    logic        fl_seen;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cycles++;
            if (bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.mem_re) rq.push_back(bus.mem_addr);
            if (int_ack) begin acks++; ack_pos = busy_cycles; end
            if (pc_load) begin
                loads++; pc_seen = pc_out; flags_seen = flags_out; fl_seen = flags_load;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] w_at(input int i);
        return (wq.size() > i) ? wq[i] : 28'hFFFFFFF;
    endfunction

    function automatic logic [11:0] r_at(input int i);
        return (rq.size() > i) ? rq[i] : 12'hBAD;
    endfunction

    task automatic clear_log();
        wq.delete(); rq.delete();
        busy_cycles = 0; acks = 0; ack_pos = 0; loads = 0;
        pc_seen = '0; flags_seen = '0; fl_seen = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", busy, 0);
    endtask

    // r = {int, rti, ret, call}
    task automatic issue(input logic [3:0] r);
        @(negedge clk);
        {int_req, rti_req, ret_req, call_req} = r;
        @(negedge clk);
        {int_req, rti_req, ret_req, call_req} = 4'b0000;
    endtask

    initial begin
        clear_log();
        repeat (3) @(negedge clk);
        check("rst_sp", sp, 12'hFFF);
        check("rst_busy", busy, 0);
        check("rst_strobes", {bus.mem_we, bus.mem_re, pc_load, flags_load, int_ack}, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_flags_out", flags_out, 0);
`ifdef STACK_GUARD_EN
        check("rst_fault", stack_fault, 0);
`endif
        rst_n = 1'b1;

        // 1: CALL pushes hi then lo; later pc_in changes are ignored
        clear_log();
        pc_in = 32'h0001_2345;
        issue(4'b0001);
        pc_in = 32'hDEAD_BEEF;
        wait_idle();
        check("call_nw", wq.size(), 2);
        check("call_w0", w_at(0), {12'hFFF, 16'h0001});
        check("call_w1", w_at(1), {12'hFFE, 16'h2345});
        check("call_busy", busy_cycles, 2);
        check("call_sp", sp, 12'hFFD);

        // 2: RET pops back the return address
        clear_log();
        issue(4'b0010);
        wait_idle();
        check("ret_nr", rq.size(), 2);
        check("ret_r0", r_at(0), 12'hFFE);
        check("ret_r1", r_at(1), 12'hFFF);
        check("ret_loads", loads, 1);
        check("ret_pc", pc_seen, 32'h0001_2345);
        check("ret_no_flags_load", fl_seen, 0);
        check("ret_sp", sp, 12'hFFF);

        // 3: INT then RTI
        clear_log();
        pc_in = 32'h0000_0040; flags_in = 4'hA;
        issue(4'b1000);
        wait_idle();
        check("int_w0", w_at(0), {12'hFFF, 16'h0000});
        check("int_w1", w_at(1), {12'hFFE, 16'h0040});
        check("int_w2", w_at(2), {12'hFFD, 16'h000A});
        check("int_acks", acks, 1);
        check("int_ack_pos", ack_pos, 3);
        check("int_sp", sp, 12'hFFC);
        clear_log();
        issue(4'b0100);
        wait_idle();
        check("rti_r", {r_at(0), r_at(1), r_at(2)}, {12'hFFD, 12'hFFE, 12'hFFF});
        check("rti_pc", pc_seen, 32'h0000_0040);
        check("rti_flags", flags_seen, 4'hA);
        check("rti_flags_load", fl_seen, 1);
        check("rti_sp", sp, 12'hFFF);

        // 4a: simultaneous CALL and INT -> INT wins, CALL dropped
        clear_log();
        pc_in = 32'h0000_1111; flags_in = 4'h5;
        issue(4'b1001);
        wait_idle();
        repeat (4) @(negedge clk);
        check("arb_nw", wq.size(), 3);
        check("arb_w1", w_at(1), {12'hFFE, 16'h1111});
        check("arb_acks", acks, 1);
        check("arb_sp", sp, 12'hFFC);

        // 4b: INT raised mid-CALL is held pending and runs right after
        clear_log();
        pc_in = 32'h0000_2222;
        @(negedge clk); call_req = 1'b1;
        @(negedge clk); call_req = 1'b0; int_req = 1'b1; pc_in = 32'h0000_3333; flags_in = 4'h3;
        @(negedge clk); int_req = 1'b0;
        wait_idle();
        check("pend_gap_idle", busy, 0);
        wait_idle();
        repeat (5) @(negedge clk);
        check("pend_nw", wq.size(), 5);
        check("pend_call_lo", w_at(1), {12'hFFB, 16'h2222});
        check("pend_int_lo", w_at(3), {12'hFF9, 16'h3333});
        check("pend_int_f", w_at(4), {12'hFF8, 16'h0003});
        check("pend_acks", acks, 1);
        check("pend_sp", sp, 12'hFF7);

        // 5: reset during PUSH_L of CALL
        clear_log();
        pc_in = 32'h0005_0006;
        issue(4'b0001);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_we", bus.mem_we, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_nw", wq.size(), 1);
        check("abort_sp", sp, 12'hFFF);

        // 6: drive sp to 0, then CALL at the bottom of the stack
        issue(4'b1000);
        wait_idle();
        pc_in = '0;
        for (int i = 0; i < 2046; i++) begin
            issue(4'b0001);
            wait_idle();
        end
        check("fill_sp", sp, 12'h000);
        clear_log();
        pc_in = 32'h00BE_00EF;
        issue(4'b0001);
        wait_idle();
`ifdef STACK_GUARD_EN
        check("guard_nw", wq.size(), 0);
        check("guard_fault", stack_fault, 1);
        check("guard_busy", busy_cycles, 1);
        check("guard_sp", sp, 12'h000);
`else
        check("wrap_w0", w_at(0), {12'h000, 16'h00BE});
        check("wrap_w1", w_at(1), {12'hFFF, 16'h00EF});
        check("wrap_sp", sp, 12'hFFE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
